idli_dout_m: RTL and testbench
==============================

Name: idli_dout_m

Overview:
- Output-side stage directly downstream of the core datapath. Drives the core's external data-output interface (dout nibble / valid / accept).
- Captures 16-bit words from the core as four nibbles, one per counter cycle, aligned to the core's 4-cycle period.
- Buffers up to DEPTH complete words and replays them to the external consumer one nibble per accepted beat, least-significant nibble first.
- Gives the core a full indication and a sticky overflow flag.

Parameters:
- DEPTH, 2, number of 16-bit word entries; power of two, minimum 2.

Ports:
- i_dout_gck  input  1  core clock; all state updates on rising edge.
- i_dout_rst  input  1  synchronous reset, active-high.
- i_dout_ctr  input  2  core period counter, 0..3; nibble index of the current cycle.
- i_dout_ctr_last_cycle  input  1  high when i_dout_ctr==3.
- i_dout_wr  input  1  core is writing a word this period; held constant across all 4 cycles.
- i_dout_wr_data  input  4  write nibble for the current cycle; cycle with ctr==N carries bits [4N+3:4N].
- o_dout_full  output  1  all DEPTH entries committed; core must not start a write period.
- o_dout_ovf  output  1  sticky: a write period was discarded because the buffer was full.
- o_dout_data  output  4  current output nibble; 0 when o_dout_vld is low.
- o_dout_vld  output  1  o_dout_data is valid.
- i_dout_acp  input  1  external consumer accepts the nibble this cycle.

Behaviour:
- Reset (i_dout_rst high at rising edge):
  - count, wr_ptr, rd_ptr, rd_nib and the accept latch all go to 0.
  - Outputs after the edge: o_dout_full=0, o_dout_ovf=0, o_dout_vld=0, o_dout_data=0.
  - Any partially captured or partially drained word is discarded. Entry storage needs no reset.
- Write acceptance is decided at ctr==0:
  - If i_dout_wr && !o_dout_full, set the period-accept latch.
  - If i_dout_wr && o_dout_full, clear the latch and set o_dout_ovf (stays set until reset).
- Capture: while the latch is set (or at ctr==0 when it is being set) and i_dout_wr is high, write the nibble into entry[wr_ptr], slot ctr.
- Commit:
  - At ctr==3 with latch set and i_dout_wr high: count+1 and wr_ptr+1 (wraps modulo DEPTH) at that edge.
  - The word is visible (o_dout_vld=1) in the cycle after the ctr==3 edge. Latency is one cycle from the last nibble.
- Abandoned write: if i_dout_wr goes low mid-period while the latch is set, clear the latch and do not commit. No ovf in this case.
- Reserved slot: a period accepted at ctr==0 keeps its tail slot even if a pop occurs mid-period. count can only fall during the period, so the tail never collides with the head.
- Read side:
  - o_dout_vld = (count != 0).
  - o_dout_data = entry[rd_ptr] nibble rd_nib when valid, else 0.
  - On o_dout_vld && i_dout_acp: rd_nib+1.
  - If rd_nib==3, pop instead: rd_nib=0, rd_ptr+1 (wraps), count-1.
  - i_dout_acp while !o_dout_vld is ignored.
  - o_dout_data and o_dout_vld hold stable until accepted.
- Simultaneous commit and pop in one cycle: count unchanged, both pointers advance.
- o_dout_full = (count == DEPTH), registered from count, so it updates the cycle after commit/pop.
- Throughput: continuous acp drains one word per 4 cycles, matching the core's write rate, so there are no bubbles in steady state.

Test Plan:
- Reset then write 0xBEEF (nibbles F,E,E,B on ctr 0..3) with acp held 1 -> vld rises the cycle after ctr==3; data F,E,E,B on 4 consecutive cycles; then vld=0, data=0.
- Write 0xBEEF with acp=0 for 10 cycles -> vld=1 and data=F stable throughout. Pulse acp for 1 cycle -> data becomes E; full=0 throughout.
- DEPTH=2, acp=0: write 0x1234, then 0x5678 -> full=1. Write 0x9ABC -> ovf=1, count stays 2. Drain with acp=1 -> 4,3,2,1,8,7,6,5, then vld=0; ovf stays 1.
- One word queued; acp timed so its final nibble pops on the same edge a new word 0xA5C3 commits -> count stays 1, vld never drops, next nibbles 3,C,5,A.
- Start write 0x1111, drop i_dout_wr at ctr==2 -> no commit, vld stays 0, ovf=0. The next full write of 0x2222 drains as 2,2,2,2.
- Reset asserted mid-drain of a full buffer -> next cycle vld=0, data=0, full=0, ovf=0. A following write of 0x00F0 drains as 0,F,0,0.

Source files
------------

// File: rtl/idli_dout_m.sv
// Output stage of the core: captures 16-bit words a nibble per cycle, buffers up to
// DEPTH of them and replays them least-significant nibble first under consumer accept.
module idli_dout_m #(
    parameter int DEPTH = 2
) (
    input  logic       i_dout_gck,
    input  logic       i_dout_rst,
    input  logic [1:0] i_dout_ctr,
    input  logic       i_dout_ctr_last_cycle,
    input  logic       i_dout_wr,
    input  logic [3:0] i_dout_wr_data,
    output logic       o_dout_full,
    output logic       o_dout_ovf,
    output logic [3:0] o_dout_data,
    output logic       o_dout_vld,
    input  logic       i_dout_acp
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Entry storage is one nibble per slot, addressed as {entry, nibble}.
    logic [3:0]       mem_q [DEPTH*4];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]       rd_nib_q, rd_nib_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             full_q;
    logic             capture;
    logic             commit;
    logic             pop;
    logic             vld;

    assign vld = (count_q != '0);

    // NOTE: every signal assigned here gets a default first, otherwise a missed branch infers a latch.
    always_comb begin
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rd_nib_d = rd_nib_q;
        capture  = 1'b0;

        // Acceptance is decided once per period; a full buffer discards the whole period.
        if (i_dout_ctr == 2'd0) begin
            if (i_dout_wr) begin
                acc_d   = !full_q;
                ovf_d   = ovf_q | full_q;
                capture = !full_q;
            end else begin
                acc_d = 1'b0;
            end
        end else if (acc_q) begin
            if (i_dout_wr) begin
                capture = 1'b1;
            end else begin
                acc_d = 1'b0;
            end
        end

        commit = capture && i_dout_ctr_last_cycle;
        if (commit) begin
            acc_d    = 1'b0;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        pop = vld && i_dout_acp && (rd_nib_q == 2'd3);
        if (vld && i_dout_acp) begin
            rd_nib_d = rd_nib_q + 2'd1;
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end

        count_d = count_q + CNT_W'(commit) - CNT_W'(pop);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_dout_gck) begin
        if (i_dout_rst) begin
            acc_q    <= 1'b0;
            ovf_q    <= 1'b0;
            full_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rd_nib_q <= '0;
            count_q  <= '0;
        end else begin
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            full_q   <= (count_d == CNT_FULL);
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rd_nib_q <= rd_nib_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left unreset; count gates every read, so stale contents are never visible.
    always_ff @(posedge i_dout_gck) begin
        if (capture) begin
            mem_q[{wr_ptr_q, i_dout_ctr}] <= i_dout_wr_data;
        end
    end

    assign o_dout_full = full_q;
    assign o_dout_ovf  = ovf_q;
    assign o_dout_vld  = vld;
    assign o_dout_data = vld ? mem_q[{rd_ptr_q, rd_nib_q}] : 4'h0;

endmodule

// File: tb/tb_idli_dout_m.sv
// Self-checking bench for idli_dout_m: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a word-queue model.
module tb_idli_dout_m;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [1:0] ctr_i = 2'd0;
    logic       last_i = 1'b0;
    logic       wr_i = 1'b0;
    logic [3:0] wr_data_i = 4'h0;
    logic       acp_i = 1'b0;
    logic       full_o;
    logic       ovf_o;
    logic [3:0] data_o;
    logic       vld_o;

    idli_dout_m #(.DEPTH(DEPTH)) dut (
        .i_dout_gck            (clk),
        .i_dout_rst            (rst_i),
        .i_dout_ctr            (ctr_i),
        .i_dout_ctr_last_cycle (last_i),
        .i_dout_wr             (wr_i),
        .i_dout_wr_data        (wr_data_i),
        .o_dout_full           (full_o),
        .o_dout_ovf            (ovf_o),
        .o_dout_data           (data_o),
        .o_dout_vld            (vld_o),
        .i_dout_acp            (acp_i)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: committed words in a queue, head nibble index, period accept, sticky ovf.
    logic [15:0] m_q[$];
    int          m_nib = 0;
    bit          m_latch = 0;
    bit          m_ovf = 0;
    logic [15:0] m_cur = '0;
    bit          model_ok = 0;
    logic [1:0]  ctr_cnt = 2'd0;

    function automatic void model_step(bit rst, logic [1:0] ctr, bit wr, logic [3:0] d, bit acp);
        bit full_pre;
        bit commit;
        if (rst) begin
            m_q.delete();
            m_nib    = 0;
            m_latch  = 0;
            m_ovf    = 0;
            model_ok = 1;
            return;
        end
        full_pre = (m_q.size() == DEPTH);
        commit   = 0;
        if (ctr == 2'd0) begin
            if (!wr) m_latch = 0;
            else if (full_pre) begin
                m_latch = 0;
                m_ovf   = 1;
            end else begin
                m_latch    = 1;
                m_cur[3:0] = d;
            end
        end else if (m_latch) begin
            if (!wr) m_latch = 0;
            else begin
                m_cur[4*int'(ctr) +: 4] = d;
                if (ctr == 2'd3) begin
                    commit  = 1;
                    m_latch = 0;
                end
            end
        end
        if (m_q.size() != 0 && acp) begin
            if (m_nib == 3) begin
                m_nib = 0;
                void'(m_q.pop_front());
            end else begin
                m_nib++;
            end
        end
        if (commit) m_q.push_back(m_cur);
    endfunction

    always @(negedge clk) begin
        if (model_ok) begin
            logic [15:0] head;
            logic [3:0]  exp_data;
            exp_data = 4'h0;
            if (m_q.size() != 0) begin
                head     = m_q[0];
                exp_data = head[4*m_nib +: 4];
            end
            check("cmp_vld",  vld_o,  m_q.size() != 0);
            check("cmp_data", data_o, exp_data);
            check("cmp_full", full_o, m_q.size() == DEPTH);
            check("cmp_ovf",  ovf_o,  m_ovf);
        end
    end

    task automatic tick(input bit rst, input bit wr, input logic [3:0] d, input bit acp);
        @(negedge clk);
        rst_i     = rst;
        ctr_i     = ctr_cnt;
        last_i    = (ctr_cnt == 2'd3);
        wr_i      = wr;
        wr_data_i = d;
        acp_i     = acp;
        @(posedge clk);
        model_step(rst, ctr_cnt, wr, d, acp);
        ctr_cnt = rst ? 2'd0 : ctr_cnt + 2'd1;
        #1;
    endtask

    task automatic do_reset();
        tick(1, 0, 4'h0, 0);
    endtask

    // One core period; wr drops from cycle drop_at onwards; acp_mode 0/1 constant, 2 random.
    task automatic period(input bit wr_en, input logic [15:0] w, input int drop_at, input int acp_mode);
        while (ctr_cnt != 2'd0) tick(0, 0, 4'h0, 0);
        for (int i = 0; i < 4; i++) begin
            tick(0, wr_en && (i < drop_at), w[4*i +: 4],
                 (acp_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(acp_mode));
        end
    endtask

    task automatic expect_drain(input logic [15:0] w);
        for (int i = 0; i < 4; i++) begin
            check("drain_vld", vld_o, 1'b1);
            check("drain_data", data_o, w[4*i +: 4]);
            tick(0, 0, 4'h0, 1);
        end
    endtask

    initial begin
        // Basic write with acp held: one-cycle latency, nibbles F,E,E,B.
        do_reset();
        check("rst_vld", vld_o, 0);
        check("rst_data", data_o, 0);
        check("rst_full", full_o, 0);
        check("rst_ovf", ovf_o, 0);
        period(1, 16'hBEEF, 4, 1);
        expect_drain(16'hBEEF);
        check("empty_vld", vld_o, 0);
        check("empty_data", data_o, 0);

        // Output holds while not accepted.
        do_reset();
        period(1, 16'hBEEF, 4, 0);
        for (int i = 0; i < 10; i++) begin
            check("hold_data", data_o, 4'hF);
            check("hold_full", full_o, 0);
            tick(0, 0, 4'h0, 0);
        end
        tick(0, 0, 4'h0, 1);
        check("pulse_data", data_o, 4'hE);

        // Fill, overflow, drain.
        do_reset();
        period(1, 16'h1234, 4, 0);
        check("one_full", full_o, 0);
        period(1, 16'h5678, 4, 0);
        check("two_full", full_o, 1);
        period(1, 16'h9ABC, 4, 0);
        check("ovf_set", ovf_o, 1);
        expect_drain(16'h1234);
        expect_drain(16'h5678);
        check("drained_vld", vld_o, 0);
        check("ovf_sticky", ovf_o, 1);

        // Pop and commit on the same edge.
        do_reset();
        period(1, 16'h1234, 4, 0);
        period(1, 16'hA5C3, 4, 1);
        check("same_edge_full", full_o, 0);
        expect_drain(16'hA5C3);

        // Abandoned write leaves nothing behind.
        do_reset();
        period(1, 16'h1111, 2, 0);
        check("abandon_vld", vld_o, 0);
        check("abandon_ovf", ovf_o, 0);
        period(1, 16'h2222, 4, 0);
        expect_drain(16'h2222);

        // Reset mid-drain of a full, overflowed buffer.
        do_reset();
        period(1, 16'h1357, 4, 0);
        period(1, 16'h2468, 4, 0);
        period(1, 16'hFFFF, 4, 0);
        tick(0, 0, 4'h0, 1);
        tick(0, 0, 4'h0, 1);
        do_reset();
        check("mid_rst_vld", vld_o, 0);
        check("mid_rst_data", data_o, 0);
        check("mid_rst_full", full_o, 0);
        check("mid_rst_ovf", ovf_o, 0);
        period(1, 16'h00F0, 4, 0);
        expect_drain(16'h00F0);

        // Randomized traffic against the model.
        do_reset();
        for (int p = 0; p < 400; p++) begin
            if ($urandom_range(0, 59) == 0) do_reset();
            period($urandom_range(0, 9) < 7, 16'($urandom),
                   ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 4,
                   (p % 50 < 10) ? 0 : 2);
        end
        repeat (12) tick(0, 0, 4'h0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
